gc_arb: RTL and testbench

GC_ARB -- requirements
Module: gc_arb

---
 rtl/gc_arb.sv | 109 ++++++++++
 tb/tb_gc_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gc_arb.sv
// rtl/gc_arb.sv - two-slot gc-update arbiter sharing one TLP writer, strict 0,1,0,1 order.
// Optional build macro GC_ARB_COALESCE_EN merges simultaneous slot requests into one update.
module gc_arb #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gc0_updt,
   input  logic [63:0]      gc0_addr,
   output logic             gc0_updt_ack,
   input  logic             gc1_updt,
   input  logic [63:0]      gc1_addr,
   output logic             gc1_updt_ack,
   output logic             gc_updt,
   output logic [63:0]      gc_addr,
   input  logic             gc_updt_ack,
   output logic [CNT_W-1:0] gc_updt_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t      state, state_n;
   logic        exp_slot;
   logic        coal_q;
   logic        exp_req;
   logic        coal_req;
   logic        load;
   logic        coal_load;
   logic        done;
   logic [63:0] load_addr;

   assign exp_req = exp_slot ? gc1_updt : gc0_updt;

`ifdef GC_ARB_COALESCE_EN
   assign coal_req = gc0_updt & gc1_updt;
`else
   assign coal_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      load      = 1'b0;
      coal_load = 1'b0;
      load_addr = 64'd0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            // Coalescing publishes the newer address, i.e. the non-expected slot's.
            if (coal_req) begin
               load      = 1'b1;
               coal_load = 1'b1;
               load_addr = exp_slot ? gc0_addr : gc1_addr;
               state_n   = ISSUE;
            end else if (exp_req) begin
               load      = 1'b1;
               load_addr = exp_slot ? gc1_addr : gc0_addr;
               state_n   = ISSUE;
            end
         end
         ISSUE: begin
            if (gc_updt_ack) begin
               done    = 1'b1;
               state_n = HOLD;
            end
         end
         HOLD:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gc_updt      <= 1'b0;
         gc_addr      <= 64'd0;
         gc0_updt_ack <= 1'b0;
         gc1_updt_ack <= 1'b0;
         gc_updt_cnt  <= '0;
         exp_slot     <= 1'b0;
         coal_q       <= 1'b0;
      end else begin
         gc0_updt_ack <= 1'b0;
         gc1_updt_ack <= 1'b0;
         if (load) begin
            gc_updt <= 1'b1;
            gc_addr <= load_addr;
            coal_q  <= coal_load;
         end
         if (done) begin
            gc_updt     <= 1'b0;
            gc_updt_cnt <= gc_updt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            // A coalesced update serves both slots, so exp_slot toggles twice (net unchanged).
            if (coal_q) begin
               gc0_updt_ack <= 1'b1;
               gc1_updt_ack <= 1'b1;
            end else begin
               gc0_updt_ack <= ~exp_slot;
               gc1_updt_ack <= exp_slot;
               exp_slot     <= ~exp_slot;
            end
         end
      end
   end

endmodule

// File: tb/tb_gc_arb.sv
// tb/tb_gc_arb.sv - directed scoreboard bench for gc_arb (CNT_W=4).
module tb_gc_arb;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             gc0_updt = 1'b0;
   logic [63:0]      gc0_addr = 64'd0;
   logic             gc0_updt_ack;
   logic             gc1_updt = 1'b0;
   logic [63:0]      gc1_addr = 64'd0;
   logic             gc1_updt_ack;
   logic             gc_updt;
   logic [63:0]      gc_addr;
   logic             gc_updt_ack = 1'b0;
   logic [CNT_W-1:0] gc_updt_cnt;

   typedef struct {
      logic [63:0] addr;
      logic        a0;
      logic        a1;
   } sb_t;

   sb_t              sb[$];
   int               total = 0;
   int               passed = 0;
   logic [CNT_W-1:0] cnt_m = '0;
   logic             exp_m = 1'b0;
   int               gap;

   gc_arb #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .gc0_updt     (gc0_updt),
      .gc0_addr     (gc0_addr),
      .gc0_updt_ack (gc0_updt_ack),
      .gc1_updt     (gc1_updt),
      .gc1_addr     (gc1_addr),
      .gc1_updt_ack (gc1_updt_ack),
      .gc_updt      (gc_updt),
      .gc_addr      (gc_addr),
      .gc_updt_ack  (gc_updt_ack),
      .gc_updt_cnt  (gc_updt_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      assert (obs === want) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
   endtask

   task automatic push(input logic [63:0] addr, input logic a0, input logic a1);
      sb_t item;
      item.addr = addr;
      item.a0   = a0;
      item.a1   = a1;
      sb.push_back(item);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      gc0_updt = 1'b0;
      gc1_updt = 1'b0;
      gc_updt_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt_m = '0;
      exp_m = 1'b0;
      sb.delete();
   endtask

   // Wait for the next downstream update, compare it with the scoreboard head,
   // ack it after hold_cyc cycles, then check the slot ack pulse and counters.
   task automatic serve(input int hold_cyc, output int gap_o);
      sb_t item;
      gap_o = 0;
      while (gc_updt !== 1'b1 && gap_o < 20) begin
         gap_o++;
         @(negedge clk);
      end
      check("updt_rise", gc_updt, 1'b1);
      if (sb.size() == 0) begin
         check("sb_nonempty", 64'd0, 64'd1);
         item.addr = 64'd0;
         item.a0   = 1'b0;
         item.a1   = 1'b0;
      end else begin
         item = sb.pop_front();
      end
      check("addr", gc_addr, item.addr);
      for (int i = 0; i < hold_cyc; i++) begin
         @(negedge clk);
         check("updt_held", gc_updt, 1'b1);
         check("addr_held", gc_addr, item.addr);
      end
      gc_updt_ack = 1'b1;
      @(negedge clk);
      gc_updt_ack = 1'b0;
      cnt_m = cnt_m + 1'b1;
      if (!(item.a0 && item.a1)) exp_m = ~exp_m;
      check("updt_drop", gc_updt, 1'b0);
      check("ack0", gc0_updt_ack, item.a0);
      check("ack1", gc1_updt_ack, item.a1);
      check("cnt", gc_updt_cnt, cnt_m);
      check("exp_slot", dut.exp_slot, exp_m);
      if (item.a0) gc0_updt = 1'b0;
      if (item.a1) gc1_updt = 1'b0;
      @(negedge clk);
      check("ack0_pulse", gc0_updt_ack, 1'b0);
      check("ack1_pulse", gc1_updt_ack, 1'b0);
   endtask

   initial begin
      // Reset state.
      @(negedge clk);
      check("rst_updt", gc_updt, 1'b0);
      check("rst_addr", gc_addr, 64'd0);
      check("rst_ack0", gc0_updt_ack, 1'b0);
      check("rst_ack1", gc1_updt_ack, 1'b0);
      check("rst_cnt", gc_updt_cnt, 0);
      check("rst_exp", dut.exp_slot, 1'b0);
      do_reset();

      // Stray downstream ack while idle is ignored.
      gc_updt_ack = 1'b1;
      @(negedge clk);
      gc_updt_ack = 1'b0;
      @(negedge clk);
      check("idle_ack_cnt", gc_updt_cnt, 0);
      check("idle_ack_updt", gc_updt, 1'b0);
      check("idle_ack_a0", gc0_updt_ack, 1'b0);

      // Single slot-0 update, ack 3 cycles after gc_updt.
      gc0_addr = 64'h1000;
      gc0_updt = 1'b1;
      push(64'h1000, 1'b1, 1'b0);
      serve(3, gap);

      // Out-of-order slot 1 held pending, then served after slot 0.
      do_reset();
      gc1_addr = 64'h2000;
      gc1_updt = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("pend_updt", gc_updt, 1'b0);
         check("pend_ack1", gc1_updt_ack, 1'b0);
      end
      gc0_addr = 64'h1000;
      gc0_updt = 1'b1;
      push(64'h1000, 1'b1, 1'b0);
      push(64'h2000, 1'b0, 1'b1);
      serve(1, gap);
      serve(2, gap);

      // Both requests together.
      do_reset();
      gc0_addr = 64'h1000;
      gc1_addr = 64'h2000;
      gc0_updt = 1'b1;
      gc1_updt = 1'b1;
`ifdef GC_ARB_COALESCE_EN
      push(64'h2000, 1'b1, 1'b1);
      serve(2, gap);
      check("coal_cnt", gc_updt_cnt, 1);
      check("coal_exp", dut.exp_slot, 1'b0);
      repeat (4) @(negedge clk);
      check("coal_no_more", gc_updt, 1'b0);
`else
      push(64'h1000, 1'b1, 1'b0);
      push(64'h2000, 1'b0, 1'b1);
      serve(2, gap);
      serve(0, gap);
      check("min_gap", gap, 1);
      check("both_cnt", gc_updt_cnt, 2);
`endif

      // Reset while an update awaits its ack.
      do_reset();
      gc0_addr = 64'h1000;
      gc0_updt = 1'b1;
      push(64'h1000, 1'b1, 1'b0);
      gap = 0;
      while (gc_updt !== 1'b1 && gap < 20) begin
         gap++;
         @(negedge clk);
      end
      check("pre_rst_updt", gc_updt, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_updt", gc_updt, 1'b0);
      check("mid_rst_ack0", gc0_updt_ack, 1'b0);
      check("mid_rst_cnt", gc_updt_cnt, 0);
      serve(1, gap);

      // Counter wrap: 15 updates then one more.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) begin
            gc0_addr = 64'h1000 + 64'(i);
            gc0_updt = 1'b1;
            push(64'h1000 + 64'(i), 1'b1, 1'b0);
         end else begin
            gc1_addr = 64'h2000 + 64'(i);
            gc1_updt = 1'b1;
            push(64'h2000 + 64'(i), 1'b0, 1'b1);
         end
         serve(0, gap);
      end
      check("cnt_wrap", gc_updt_cnt, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
